// File: rtl/posit_fmau_arbiter_if.sv
// Bundle of request, FMAU and response signals around posit_fmau_arbiter.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface posit_fmau_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) ();
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [32*NREQ-1:0] req_a;
   logic [32*NREQ-1:0] req_b;
   logic [32*NREQ-1:0] req_c;
   logic [32*NREQ-1:0] req_d;
   logic [2*NREQ-1:0]  req_in_pre;
   logic [2*NREQ-1:0]  req_out_pre;

   logic               fmau_start;
   logic [31:0]        fmau_a;
   logic [31:0]        fmau_b;
   logic [31:0]        fmau_c;
   logic [31:0]        fmau_d;
   logic [1:0]         fmau_in_pre;
   logic [1:0]         fmau_out_pre;
   logic [31:0]        fmau_out;
   logic               fmau_soe;

   logic               rsp_valid;
   logic               rsp_ready;
   logic [31:0]        rsp_data;
   logic [IDW-1:0]     rsp_id;
   logic               rsp_err;
   logic               busy;

   modport slave (
      input  req_valid, req_a, req_b, req_c, req_d, req_in_pre, req_out_pre,
      output req_ready,
      output fmau_start, fmau_a, fmau_b, fmau_c, fmau_d, fmau_in_pre, fmau_out_pre,
      input  fmau_out, fmau_soe,
      output rsp_valid, rsp_data, rsp_id, rsp_err, busy,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_a, req_b, req_c, req_d, req_in_pre, req_out_pre,
      input  req_ready,
      input  fmau_start, fmau_a, fmau_b, fmau_c, fmau_d, fmau_in_pre, fmau_out_pre,
      output fmau_out, fmau_soe,
      input  rsp_valid, rsp_data, rsp_id, rsp_err, busy,
      output rsp_ready
   );
endinterface

// File: rtl/posit_fmau_arbiter.sv
// Round-robin arbiter sharing one posit FMAU among NREQ requesters, one op at a time.
// Define FMAU_ARB_TIMEOUT_EN to add a watchdog that aborts a hung op with NaR and rsp_err.
module posit_fmau_arbiter #(
   parameter int NREQ      = 4,
   parameter int IDW       = 2,
   parameter int START_CYC = 1,
   parameter int TIMEOUT   = 64
) (
   input logic                 clk,
   input logic                 rst,
   posit_fmau_arbiter_if.slave bus
);
   localparam int SCW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
   localparam logic [SCW-1:0] START_LAST = SCW'(START_CYC - 1);
   localparam logic [31:0]    POSIT_NAR  = 32'h8000_0000;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state_q;
   logic [IDW-1:0]  rr_ptr_q;
   logic [SCW-1:0]  start_cnt_q;
   logic            fmau_start_q;
   logic [31:0]     fmau_a_q;
   logic [31:0]     fmau_b_q;
   logic [31:0]     fmau_c_q;
   logic [31:0]     fmau_d_q;
   logic [1:0]      fmau_in_pre_q;
   logic [1:0]      fmau_out_pre_q;
   logic            rsp_valid_q;
   logic [31:0]     rsp_data_q;
   logic [IDW-1:0]  rsp_id_q;
   logic            rsp_err_q;
   logic            busy_q;

   logic [31:0]     op_a      [NREQ];
   logic [31:0]     op_b      [NREQ];
   logic [31:0]     op_c      [NREQ];
   logic [31:0]     op_d      [NREQ];
   logic [1:0]      op_in_pre [NREQ];
   logic [1:0]      op_out_pre[NREQ];

   logic [NREQ-1:0] req_rot;
   logic            grant_found;
   logic [IDW-1:0]  grant_idx;
   logic [NREQ-1:0] grant_onehot;
   logic [IDW-1:0]  rr_next;
   logic            wd_expired;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_slice
         assign op_a[gi]       = bus.req_a[32*gi +: 32];
         assign op_b[gi]       = bus.req_b[32*gi +: 32];
         assign op_c[gi]       = bus.req_c[32*gi +: 32];
         assign op_d[gi]       = bus.req_d[32*gi +: 32];
         assign op_in_pre[gi]  = bus.req_in_pre[2*gi +: 2];
         assign op_out_pre[gi] = bus.req_out_pre[2*gi +: 2];
      end
   endgenerate

   // Rotate the request vector so bit 0 is the requester at rr_ptr, then take the lowest set bit.
   assign req_rot = NREQ'({bus.req_valid, bus.req_valid} >> rr_ptr_q);

   always_comb begin
      logic [IDW:0] sum;
      grant_found = 1'b0;
      grant_idx   = '0;
      sum         = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
               sum = sum - (IDW+1)'(NREQ);
            end
            grant_found = 1'b1;
            grant_idx   = sum[IDW-1:0];
         end
      end
   end

   assign grant_onehot = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx;
   assign rr_next      = (rsp_id_q == IDW'(NREQ - 1)) ? '0 : rsp_id_q + 1'b1;

`ifdef FMAU_ARB_TIMEOUT_EN
   logic [15:0] wd_cnt_q;

   // Held at zero outside ISSUE/WAIT so it starts from zero on every ISSUE entry.
   always_ff @(posedge clk) begin
      if (rst || state_q == IDLE || state_q == RESP) begin
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_q + 16'd1;
      end
   end

   assign wd_expired = (wd_cnt_q == 16'(TIMEOUT - 1));
`else
   assign wd_expired = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         rr_ptr_q       <= '0;
         start_cnt_q    <= '0;
         fmau_start_q   <= 1'b0;
         fmau_a_q       <= '0;
         fmau_b_q       <= '0;
         fmau_c_q       <= '0;
         fmau_d_q       <= '0;
         fmau_in_pre_q  <= '0;
         fmau_out_pre_q <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_data_q     <= '0;
         rsp_id_q       <= '0;
         rsp_err_q      <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_found) begin
                  fmau_a_q       <= op_a[grant_idx];
                  fmau_b_q       <= op_b[grant_idx];
                  fmau_c_q       <= op_c[grant_idx];
                  fmau_d_q       <= op_d[grant_idx];
                  fmau_in_pre_q  <= op_in_pre[grant_idx];
                  fmau_out_pre_q <= op_out_pre[grant_idx];
                  rsp_id_q       <= grant_idx;
                  start_cnt_q    <= '0;
                  fmau_start_q   <= 1'b1;
                  busy_q         <= 1'b1;
                  state_q        <= ISSUE;
               end
            end
            ISSUE, WAIT: begin
               // A strobe in the same cycle as the watchdog limit still wins.
               if (bus.fmau_soe) begin
                  rsp_data_q   <= bus.fmau_out;
                  rsp_err_q    <= 1'b0;
                  rsp_valid_q  <= 1'b1;
                  fmau_start_q <= 1'b0;
                  state_q      <= RESP;
               end else if (wd_expired) begin
                  rsp_data_q   <= POSIT_NAR;
                  rsp_err_q    <= 1'b1;
                  rsp_valid_q  <= 1'b1;
                  fmau_start_q <= 1'b0;
                  state_q      <= RESP;
               end else if (state_q == ISSUE) begin
                  if (start_cnt_q == START_LAST) begin
                     fmau_start_q <= 1'b0;
                     state_q      <= WAIT;
                  end else begin
                     start_cnt_q <= start_cnt_q + 1'b1;
                  end
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  rr_ptr_q    <= rr_next;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready    = (state_q == IDLE && grant_found) ? grant_onehot : '0;
   assign bus.fmau_start   = fmau_start_q;
   assign bus.fmau_a       = fmau_a_q;
   assign bus.fmau_b       = fmau_b_q;
   assign bus.fmau_c       = fmau_c_q;
   assign bus.fmau_d       = fmau_d_q;
   assign bus.fmau_in_pre  = fmau_in_pre_q;
   assign bus.fmau_out_pre = fmau_out_pre_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_data     = rsp_data_q;
   assign bus.rsp_id       = rsp_id_q;
   assign bus.rsp_err      = rsp_err_q;
   assign bus.busy         = busy_q;
endmodule

// File: tb/tb_posit_fmau_arbiter.sv
// Scoreboard bench for posit_fmau_arbiter with a behavioural FMAU that strobes a fixed delay after start.
// The watchdog scenario is included when FMAU_ARB_TIMEOUT_EN is defined.
module tb_posit_fmau_arbiter;
   localparam int NREQ      = 4;
   localparam int IDW       = 2;
   localparam int START_CYC = 1;
`ifdef FMAU_ARB_TIMEOUT_EN
   localparam int TIMEOUT   = 8;
`else
   localparam int TIMEOUT   = 64;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   posit_fmau_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   posit_fmau_arbiter #(
      .NREQ(NREQ), .IDW(IDW), .START_CYC(START_CYC), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   typedef struct packed {
      logic [IDW-1:0] id;
      logic           err;
      logic [31:0]    data;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        model_en    = 1'b1;
   logic        model_fixed = 1'b0;
   logic [31:0] model_val   = 32'h0;
   int          model_delay = 3;

   int              n_grant = 0;
   int              n_start_cyc = 0;
   int              n_hs = 0;
   int              start_rise_cyc = 0;
   int              rise_cyc = 0;
   logic [NREQ-1:0] last_grant = '0;

   logic           prev_valid = 1'b0;
   logic           prev_ready = 1'b0;
   logic           prev_soe   = 1'b0;
   logic           prev_start = 1'b0;
   logic [31:0]    prev_data  = '0;
   logic [IDW-1:0] prev_id    = '0;
   logic           prev_err   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_slice(input int i, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d,
                            input logic [1:0] ip, input logic [1:0] op);
      bus.req_a[32*i +: 32]     = a;
      bus.req_b[32*i +: 32]     = b;
      bus.req_c[32*i +: 32]     = c;
      bus.req_d[32*i +: 32]     = d;
      bus.req_in_pre[2*i +: 2]  = ip;
      bus.req_out_pre[2*i +: 2] = op;
   endtask

   task automatic push(input logic [IDW-1:0] id, input logic err, input logic [31:0] data);
      exp_t e;
      e.id   = id;
      e.err  = err;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Hold mask on req_valid until n grants are seen, then drop it just after the last grant edge.
   task automatic grant_n(input logic [NREQ-1:0] mask, input int n);
      int got = 0;
      int guard = 0;
      bus.req_valid = mask;
      while (got < n && guard < 500) begin
         @(negedge clk);
         guard++;
         if (bus.req_ready != '0) got++;
      end
      if (got < n) fail("grant_wait");
      tick();
      bus.req_valid = '0;
   endtask

   task automatic wait_done();
      int g = 0;
      while ((exp_q.size() != 0 || bus.busy) && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (g >= 300) begin
         fail("done_wait");
         exp_q.delete();
      end
      tick();
   endtask

   // Behavioural FMAU: result strobe model_delay cycles after the first start cycle.
   initial begin
      bus.fmau_soe = 1'b0;
      bus.fmau_out = 32'hDEAD_BEEF;
      forever begin
         tick();
         if (bus.fmau_start && model_en) begin
            repeat (model_delay) @(posedge clk);
            #1;
            bus.fmau_out = model_fixed ? model_val : (bus.fmau_a ^ bus.fmau_d);
            bus.fmau_soe = 1'b1;
            tick();
            bus.fmau_soe = 1'b0;
            bus.fmau_out = 32'hDEAD_BEEF;
         end
      end
   end

   // Monitor: pops the scoreboard on every accepted response and watches protocol rules.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.rsp_valid && !prev_valid) begin
            rise_cyc = cyc;
            if (exp_q.size() > 0 && !exp_q[0].err) check("soe_to_valid", 64'(prev_soe), 64'd1);
         end
         if (bus.rsp_valid && prev_valid && !prev_ready)
            check("rsp_hold", 64'({bus.rsp_id, bus.rsp_err, bus.rsp_data}),
                  64'({prev_id, prev_err, prev_data}));
         if (bus.rsp_valid)
            check("resp_quiet", 64'({bus.req_ready, bus.fmau_start}), 64'd0);
         if (bus.req_ready != '0) begin
            n_grant++;
            last_grant = bus.req_ready;
            check("grant_idle", 64'({bus.busy, bus.rsp_valid}), 64'd0);
         end
         if (bus.fmau_start) begin
            n_start_cyc++;
            if (!prev_start) start_rise_cyc = cyc;
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            n_hs++;
            $display("rsp id=%0d err=%0d data=%h cycle=%0d", bus.rsp_id, bus.rsp_err, bus.rsp_data, cyc);
            if (exp_q.size() == 0) begin
               fail("unexpected_rsp");
            end else begin
               e = exp_q.pop_front();
               check("rsp", 64'({bus.rsp_id, bus.rsp_err, bus.rsp_data}), 64'(e));
            end
         end
      end
      prev_valid = bus.rsp_valid;
      prev_ready = bus.rsp_ready;
      prev_soe   = bus.fmau_soe;
      prev_start = bus.fmau_start;
      prev_data  = bus.rsp_data;
      prev_id    = bus.rsp_id;
      prev_err   = bus.rsp_err;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int g0;
      int s0;
      int h0;
      int guard;
      bus.req_valid   = '0;
      bus.req_a       = '0;
      bus.req_b       = '0;
      bus.req_c       = '0;
      bus.req_d       = '0;
      bus.req_in_pre  = '0;
      bus.req_out_pre = '0;
      bus.rsp_ready   = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ctrl", 64'({bus.req_ready, bus.fmau_start, bus.rsp_valid, bus.rsp_err,
                             bus.busy, bus.rsp_id, bus.fmau_in_pre, bus.fmau_out_pre}), 64'd0);
      check("rst_ab", {bus.fmau_a, bus.fmau_b}, 64'd0);
      check("rst_cd", {bus.fmau_c, bus.fmau_d}, 64'd0);
      check("rst_data", 64'(bus.rsp_data), 64'd0);
      tick();
      rst = 1'b0;

      for (int i = 0; i < NREQ; i++)
         set_slice(i, 32'hA000_0000 | 32'(i), 32'hB000_0000 | 32'(i), 32'hC000_0000 | 32'(i),
                   32'h0D00_0000 | (32'(i) << 4), 2'(i), 2'(~i));

      // Round robin from rr_ptr=0 with all requesters held valid
      push(2'd0, 1'b0, 32'hAD00_0000);
      push(2'd1, 1'b0, 32'hAD00_0011);
      push(2'd2, 1'b0, 32'hAD00_0022);
      push(2'd3, 1'b0, 32'hAD00_0033);
      push(2'd0, 1'b0, 32'hAD00_0000);
      grant_n(4'b1111, 5);
      wait_done();

      // Single op from requester 2 with a fixed FMAU result
      set_slice(2, 32'hEC5A_5A5A, 32'h5A5A_5A5A, 32'h6D5B_5ADA, 32'h5A52_5A7A, 2'b00, 2'b00);
      model_fixed = 1'b1;
      model_val   = 32'h1234_5678;
      push(2'd2, 1'b0, 32'h1234_5678);
      g0 = n_grant;
      s0 = n_start_cyc;
      grant_n(4'b0100, 1);
      @(negedge clk);
      check("op_ab", {bus.fmau_a, bus.fmau_b}, 64'hEC5A5A5A_5A5A5A5A);
      check("op_cd", {bus.fmau_c, bus.fmau_d}, 64'h6D5B5ADA_5A525A7A);
      wait_done();
      check("single_grants", 64'(n_grant - g0), 64'd1);
      check("single_onehot", 64'(last_grant), 64'b0100);
      check("single_start_cyc", 64'(n_start_cyc - s0), 64'd1);
      model_fixed = 1'b0;

      // Backpressure: response from requester 1 held while requester 0 waits
      bus.rsp_ready = 1'b0;
      push(2'd1, 1'b0, 32'hAD00_0011);
      push(2'd0, 1'b0, 32'hAD00_0000);
      grant_n(4'b0010, 1);
      @(negedge clk);
      check("pre_route", 64'({bus.fmau_in_pre, bus.fmau_out_pre}), 64'b0110);
      check("op_bc1", {bus.fmau_b, bus.fmau_c}, 64'hB0000001_C0000001);
      guard = 0;
      while (!bus.rsp_valid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.rsp_valid) fail("bp_rsp_wait");
      tick();
      bus.req_valid = 4'b0001;
      g0 = n_grant;
      s0 = n_start_cyc;
      repeat (5) tick();
      @(negedge clk);
      check("bp_valid_data", 64'({bus.rsp_valid, bus.rsp_data}), {31'd0, 1'b1, 32'hAD00_0011});
      check("bp_no_grant_start", 64'({n_grant - g0, n_start_cyc - s0}), 64'd0);
      tick();
      bus.rsp_ready = 1'b1;
      grant_n(4'b0001, 1);
      wait_done();

      // Reset in WAIT, then a stray strobe; next grant must restart from requester 0
      model_delay = 6;
      h0 = n_hs;
      grant_n(4'b0010, 1);
      tick();
      tick();
      @(negedge clk);
      check("mid_busy", 64'(bus.busy), 64'd1);
      tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      repeat (8) tick();
      @(negedge clk);
      check("abandon", 64'({n_hs - h0, 31'd0, bus.busy}), 64'd0);
      tick();
      model_delay = 3;
      push(2'd0, 1'b0, 32'hAD00_0000);
      grant_n(4'b1111, 1);
      wait_done();

`ifdef FMAU_ARB_TIMEOUT_EN
      // Watchdog: FMAU never answers
      model_en = 1'b0;
      push(2'd2, 1'b1, 32'h8000_0000);
      grant_n(4'b0100, 1);
      wait_done();
      check("timeout_cycles", 64'(rise_cyc - start_rise_cyc), 64'd8);
      model_en = 1'b1;
`endif

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
